// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx transmitter between N_REQ byte requesters.
// Optional grant locking for multi-byte packets is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*DW-1:0] req_data_i,
  input  logic [N_REQ-1:0]    req_lock_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [N_REQ-1:0]    grant_o,
  output logic [DW-1:0]       tx_data_o,
  output logic                tx_start_o,
  input  logic                idle_i,
  output logic                busy_o
);

  // state     | meaning
  // ARB       | transmitter free, choose next requester
  // START     | tx_start_o pulse, byte latched on tx_data_o
  // WAIT_BUSY | waiting for the transmitter to report busy
  // WAIT_DONE | frame on the line, waiting for idle to return
  typedef enum logic [1:0] {ARB, START, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int IW = $clog2(N_REQ);

  state_t            state;
  logic [IW-1:0]     last;
  logic [N_REQ-1:0]  eligible;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [DW-1:0]     pick_data;
  logic [N_REQ-1:0]  pick_onehot;
  logic [IW:0]       target;
  logic              can_accept;

`ifdef UART_ARB_LOCK_EN
  logic locked;

  // While locked only the current owner may be chosen again.
  assign eligible = locked ? (req_valid_i & grant_o) : req_valid_i;
`else
  logic unused_lock;

  assign eligible    = req_valid_i;
  assign unused_lock = ^req_lock_i;
`endif

  // Scan last+1, last+2, ... wrapping; the previous winner is considered last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_data  = '0;
    target     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      target = {1'b0, last} + (IW+1)'(i);
      if (target >= (IW+1)'(N_REQ)) target = target - (IW+1)'(N_REQ);
      for (int k = 0; k < N_REQ; k++) begin
        if (!pick_found && eligible[k] && (target == (IW+1)'(k))) begin
          pick_found = 1'b1;
          pick_idx   = IW'(k);
          pick_data  = req_data_i[k*DW +: DW];
        end
      end
    end
  end

  assign pick_onehot = N_REQ'(1) << pick_idx;
  assign can_accept  = (state == ARB) && idle_i && pick_found && !rst_i;
  assign req_ready_o = can_accept ? pick_onehot : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ARB;
      last       <= IW'(N_REQ - 1);
      grant_o    <= '0;
      tx_data_o  <= '0;
      tx_start_o <= 1'b0;
      busy_o     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      locked     <= 1'b0;
`endif
    end else begin
      case (state)
        ARB: begin
          tx_start_o <= 1'b0;
          if (can_accept) begin
            tx_data_o  <= pick_data;
            grant_o    <= pick_onehot;
            last       <= pick_idx;
            tx_start_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tx_start_o <= 1'b0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!idle_i) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (idle_i) begin
            busy_o <= 1'b0;
            state  <= ARB;
`ifdef UART_ARB_LOCK_EN
            if (req_lock_i[last]) begin
              locked <= 1'b1;
            end else begin
              locked  <= 1'b0;
              grant_o <= '0;
            end
`else
            grant_o <= '0;
`endif
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
